// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life generation sequencer.
package life_pkg;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_SWAP} state_t;

  // Neighbour fetch order, clockwise from the cell above.
  localparam logic [3:0] K_CENTRE      = 4'd0;
  localparam logic [3:0] K_UPPER       = 4'd1;
  localparam logic [3:0] K_UPPER_RIGHT = 4'd2;
  localparam logic [3:0] K_RIGHT       = 4'd3;
  localparam logic [3:0] K_LOWER_RIGHT = 4'd4;
  localparam logic [3:0] K_LOWER       = 4'd5;
  localparam logic [3:0] K_LOWER_LEFT  = 4'd6;
  localparam logic [3:0] K_LEFT        = 4'd7;
  localparam logic [3:0] K_UPPER_LEFT  = 4'd8;
  localparam logic [3:0] K_DONE        = 4'd9;

  function automatic logic next_cell(input logic alive, input logic [3:0] count);
    return (count == 4'd3) || (alive && (count == 4'd2));
  endfunction

endpackage

// File: rtl/life_wrap_addr.sv
// Toroidal neighbour coordinate generator: (x,y,k) -> (nx,ny).
module life_wrap_addr import life_pkg::*; #(
  parameter int MAX_I = 63,
  parameter int MAX_J = 31,
  parameter int XW    = 6,
  parameter int YW    = 5
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [3:0]    k,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny
);

  logic [XW-1:0] xm, xp;
  logic [YW-1:0] ym, yp;

  // Explicit compares so non power-of-two grids wrap correctly.
  always_comb begin
    xm = (x == '0)         ? XW'(MAX_I) : x - XW'(1);
    xp = (x == XW'(MAX_I)) ? '0         : x + XW'(1);
    ym = (y == '0)         ? YW'(MAX_J) : y - YW'(1);
    yp = (y == YW'(MAX_J)) ? '0         : y + YW'(1);
    nx = x;
    ny = y;
    case (k)
      K_UPPER:       ny = ym;
      K_UPPER_RIGHT: begin nx = xp; ny = ym; end
      K_RIGHT:       nx = xp;
      K_LOWER_RIGHT: begin nx = xp; ny = yp; end
      K_LOWER:       ny = yp;
      K_LOWER_LEFT:  begin nx = xm; ny = yp; end
      K_LEFT:        nx = xm;
      K_UPPER_LEFT:  begin nx = xm; ny = ym; end
      default: ;
    endcase
  end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer: sweeps the grid, fetches 9 cells per site, writes the
// life rule result into the opposite bank and swaps banks per generation.
module life_gen_ctrl import life_pkg::*; #(
  parameter int MAX_I = 63,
  parameter int MAX_J = 31,
  parameter int XW    = 6,
  parameter int YW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic            pause,
  output logic            busy,
  output logic            done,
  output logic [15:0]     gen_count,
  output logic            cur_bank,
  output logic            rd_en,
  output logic [YW+XW:0]  rd_addr,
  input  logic            rd_data,
  output logic            wr_en,
  output logic [YW+XW:0]  wr_addr,
  output logic            wr_data
);

  state_t          state, nxt;
  logic [XW-1:0]   x, x_nxt, nx;
  logic [YW-1:0]   y, y_nxt, ny;
  logic [3:0]      k, k_iss, iss_k, cap_k, cnt, cnt_sum;
  logic            cap_vld, alive, alive_now;
  logic            last_x, last_y, enter_fetch, issue, rd_go, swap_go;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_FETCH;
      S_FETCH: if (k == K_DONE) nxt = S_WAIT;
      S_WAIT:  nxt = S_WRITE;
      S_WRITE: nxt = (last_x && last_y) ? S_SWAP : S_FETCH;
      S_SWAP:  nxt = run ? S_FETCH : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // k counts the next index to issue; the centre read goes out on FETCH entry.
  always_comb begin
    last_x      = (x == XW'(MAX_I));
    last_y      = (y == YW'(MAX_J));
    x_nxt       = x;
    y_nxt       = y;
    if (state == S_WRITE) begin
      if (last_x) begin
        x_nxt = '0;
        y_nxt = last_y ? '0 : y + YW'(1);
      end else begin
        x_nxt = x + XW'(1);
      end
    end else if (state == S_SWAP) begin
      x_nxt = '0;
      y_nxt = '0;
    end
    k_iss       = (state == S_FETCH) ? k : K_CENTRE;
    enter_fetch = (nxt == S_FETCH) && (state != S_FETCH);
    issue       = (state == S_FETCH) && (k != K_DONE) && !pause;
    rd_go       = enter_fetch || issue;
    swap_go     = (state == S_WRITE) && (nxt == S_SWAP);
    alive_now   = (cap_vld && cap_k == K_CENTRE) ? rd_data : alive;
    cnt_sum     = cnt + {3'b000, cap_vld && (cap_k != K_CENTRE) && rd_data};
  end

  life_wrap_addr #(.MAX_I(MAX_I), .MAX_J(MAX_J), .XW(XW), .YW(YW)) u_wrap (
    .x(x_nxt), .y(y_nxt), .k(k_iss), .nx(nx), .ny(ny)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      k         <= '0;
      iss_k     <= '0;
      cap_k     <= '0;
      cap_vld   <= 1'b0;
      alive     <= 1'b0;
      cnt       <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_bank  <= 1'b0;
      gen_count <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
      if (enter_fetch) k <= K_UPPER;
      else if (issue)  k <= k + 4'd1;
      rd_en <= rd_go;
      if (rd_go) begin
        rd_addr <= {cur_bank, ny, nx};
        iss_k   <= k_iss;
      end
      cap_vld <= rd_en;
      cap_k   <= iss_k;
      alive   <= alive_now;
      cnt     <= enter_fetch ? '0 : cnt_sum;
      wr_en   <= (state == S_WAIT);
      wr_data <= (state == S_WAIT) && next_cell(alive_now, cnt_sum);
      if (state == S_WAIT) wr_addr <= {~cur_bank, y, x};
      busy    <= (nxt != S_IDLE);
      done    <= swap_go;
      if (swap_go) begin
        cur_bank  <= ~cur_bank;
        gen_count <= gen_count + 16'd1;
      end
    end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl on a 5x5 torus with a 1-cycle memory model.
module tb_life_gen_ctrl;

  localparam int MAX_I = 4, MAX_J = 4, XW = 3, YW = 3;
  localparam int AW = 1 + XW + YW;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, run = 1'b0, pause = 1'b0;
  logic          busy, done, cur_bank, rd_en, rd_data, wr_en, wr_data;
  logic [15:0]   gen_count;
  logic [AW-1:0] rd_addr, wr_addr;

  logic [127:0]  mem;
  logic [127:0]  ld_img = '0;
  logic          ld_req = 1'b0;

  life_gen_ctrl #(.MAX_I(MAX_I), .MAX_J(MAX_J), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run(run), .pause(pause),
    .busy(busy), .done(done), .gen_count(gen_count), .cur_bank(cur_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_req)     mem <= ld_img;
    else if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= rd_en ? mem[rd_addr] : 1'b0;
  end

  int n_chk = 0, n_pass = 0;
  int cyc, wr_cnt, wr_ones, ovl, idle_cyc, pause_low, timed_out;
  logic [AW-1:0] addr_at_pause, addr_after_pause;
  logic          rd_after_pause;
  logic [AW-1:0] rd_log[$];

  typedef struct {
    logic [24:0] init;
    logic [24:0] expect_img;
    int          exp_ones;
    bit          spam;
  } vec_t;
  vec_t vecs[5];

  localparam logic [24:0] HORIZ = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
  localparam logic [24:0] VERT  = (25'd1 << 7)  | (25'd1 << 12) | (25'd1 << 17);
  localparam logic [24:0] CORN  = (25'd1 << 0)  | (25'd1 << 4)  | (25'd1 << 20) | (25'd1 << 24);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] mk_img(input logic [24:0] b0);
    logic [127:0] m;
    m = '0;
    m[127:64] = '1;
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < 5; xx++)
        m[yy*8 + xx] = b0[yy*5 + xx];
    return m;
  endfunction

  function automatic logic [24:0] bank_img(input int b);
    logic [24:0] r;
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < 5; xx++)
        r[yy*5 + xx] = mem[b*64 + yy*8 + xx];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; run = 1'b0; pause = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input logic [24:0] b0);
    ld_img = mk_img(b0); ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
  endtask

  // Pulses start, then watches cycle by cycle until n_done done pulses.
  task automatic run_gen(input int n_done, input int pause_at, input bit spam);
    int dones;
    dones = 0; cyc = 0; wr_cnt = 0; wr_ones = 0; ovl = 0; idle_cyc = 0; pause_low = 0;
    timed_out = 1; rd_log.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc++;
      if (rd_en) rd_log.push_back(rd_addr);
      if (wr_en) begin wr_cnt++; if (wr_data) wr_ones++; end
      if (rd_en && wr_en) ovl++;
      if (!busy) idle_cyc++;
      if (pause_at > 0 && cyc == pause_at) addr_at_pause = rd_addr;
      if (pause_at > 0 && cyc > pause_at && cyc <= pause_at + 5 && !rd_en) pause_low++;
      if (pause_at > 0 && cyc == pause_at + 6) begin
        rd_after_pause = rd_en; addr_after_pause = rd_addr;
      end
      if (done) begin
        dones++;
        if (dones == n_done) begin run = 1'b0; timed_out = 0; break; end
      end
      pause = (pause_at > 0 && cyc >= pause_at && cyc < pause_at + 5);
      start = spam && (cyc % 37 == 0);
      tick();
    end
    pause = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] corner_rd[9];
    corner_rd = '{7'd0, 7'd32, 7'd33, 7'd1, 7'd9, 7'd8, 7'd12, 7'd4, 7'd36};

    vecs[0] = '{init: HORIZ,        expect_img: VERT,  exp_ones: 3, spam: 1'b0};
    vecs[1] = '{init: CORN,         expect_img: CORN,  exp_ones: 4, spam: 1'b0};
    vecs[2] = '{init: 25'd0,        expect_img: 25'd0, exp_ones: 0, spam: 1'b1};
    vecs[3] = '{init: 25'd1 << 12,  expect_img: 25'd0, exp_ones: 0, spam: 1'b0};
    vecs[4] = '{init: VERT,         expect_img: HORIZ, exp_ones: 3, spam: 1'b1};

    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_bank", cur_bank, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);

    foreach (vecs[i]) begin
      do_reset();
      load(vecs[i].init);
      run_gen(1, 0, vecs[i].spam);
      chk($sformatf("v%0d_timeout", i), timed_out, 0);
      chk($sformatf("v%0d_done_cyc", i), cyc, 276);
      chk($sformatf("v%0d_bank1", i), bank_img(1), vecs[i].expect_img);
      chk($sformatf("v%0d_bank0", i), bank_img(0), vecs[i].init);
      chk($sformatf("v%0d_gen", i), gen_count, 1);
      chk($sformatf("v%0d_cur_bank", i), cur_bank, 1);
      chk($sformatf("v%0d_wr_cnt", i), wr_cnt, 25);
      chk($sformatf("v%0d_wr_ones", i), wr_ones, vecs[i].exp_ones);
      chk($sformatf("v%0d_overlap", i), ovl, 0);
      chk($sformatf("v%0d_busy_lo", i), idle_cyc, 0);
      if (i == 1)
        for (int r = 0; r < 9; r++)
          chk($sformatf("corner_rd%0d", r), (rd_log.size() > r) ? rd_log[r] : 7'h7f, corner_rd[r]);
      tick();
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Free-run two generations back to back.
    do_reset();
    load(HORIZ);
    run = 1'b1;
    run_gen(2, 0, 1'b0);
    chk("fr_timeout", timed_out, 0);
    chk("fr_done_cyc", cyc, 552);
    chk("fr_no_idle", idle_cyc, 0);
    chk("fr_gen", gen_count, 2);
    chk("fr_bank", cur_bank, 0);
    chk("fr_bank0", bank_img(0), HORIZ);
    chk("fr_bank1", bank_img(1), VERT);
    chk("fr_wr_cnt", wr_cnt, 50);
    tick();
    chk("fr_idle", busy, 0);

    // Pause 5 cycles while k=4 of cell (2,2) is on the read port.
    do_reset();
    load(HORIZ);
    run_gen(1, 12*11 + 5, 1'b0);
    chk("pz_timeout", timed_out, 0);
    chk("pz_addr_k4", addr_at_pause, 7'd27);
    chk("pz_rd_low", pause_low, 5);
    chk("pz_resume", rd_after_pause, 1);
    chk("pz_addr_k5", addr_after_pause, 7'd26);
    chk("pz_done_cyc", cyc, 281);
    chk("pz_bank1", bank_img(1), VERT);

    // Asynchronous reset at cell (3,1), then a clean generation.
    do_reset();
    load(HORIZ);
    start = 1'b1; tick(); start = 1'b0;
    repeat (88) tick();
    chk("mr_rd_en", rd_en, 1);
    chk("mr_addr", rd_addr, 7'd11);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rd_en0", rd_en, 0);
    chk("mr_rd_addr", rd_addr, 0);
    chk("mr_wr", {wr_en, wr_data}, 0);
    chk("mr_wr_addr", wr_addr, 0);
    chk("mr_done", done, 0);
    chk("mr_bank", cur_bank, 0);
    chk("mr_gen", gen_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_gen(1, 0, 1'b0);
    chk("mr_timeout", timed_out, 0);
    chk("mr_done_cyc", cyc, 276);
    chk("mr_bank1", bank_img(1), VERT);
    chk("mr_gen1", gen_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
